// File: rtl/booth_tally_arbiter.sv
// booth_tally_arbiter: polling-session controller shared by several voting booths.
// It grants booth requests in round-robin order, checks that each ballot is one-hot,
// updates saturating per-candidate counters and answers each booth with ack or nack.
module booth_tally_arbiter #(
  parameter int unsigned NUM_BOOTHS = 4,
  parameter int unsigned NUM_CAND   = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         session_open,
  input  logic                         session_close,
  input  logic [NUM_BOOTHS-1:0]        booth_req,
  input  logic [NUM_BOOTHS*NUM_CAND-1:0] booth_vote,
  output logic [NUM_BOOTHS-1:0]        booth_ack,
  output logic [NUM_BOOTHS-1:0]        booth_nack,
  output logic [NUM_CAND*CNT_W-1:0]    tally,
  output logic [CNT_W+1:0]             total_votes,
  output logic [CNT_W-1:0]             reject_count,
  output logic [1:0]                   session_state,
  output logic                         results_valid
);

  localparam int unsigned IdxW  = (NUM_BOOTHS > 1) ? $clog2(NUM_BOOTHS) : 1;
  localparam int unsigned CIdxW = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StOpen   = 2'b01,
    StCommit = 2'b10,
    StClosed = 2'b11
  } state_e;

  state_e               state_q;
  logic [IdxW-1:0]      last_q;
  logic [IdxW-1:0]      gnt_q;
  logic [NUM_CAND-1:0]  ballot_q;
  logic [CNT_W-1:0]     cnt_q [NUM_CAND];
  logic [CNT_W+1:0]     total_q;
  logic [CNT_W-1:0]     rej_q;
  logic [NUM_BOOTHS-1:0] ack_q;
  logic [NUM_BOOTHS-1:0] nack_q;

  logic [IdxW-1:0]      pick;
  int                   rr_sum;
  logic [CIdxW-1:0]     cand;
  logic                 ballot_ok;

  // Round-robin pick: scan downward in priority so the closest requester after
  // last_q is the final (winning) assignment.
  always_comb begin
    pick   = last_q;
    rr_sum = 0;
    for (int k = NUM_BOOTHS; k >= 1; k--) begin
      rr_sum = (int'(last_q) + k) % int'(NUM_BOOTHS);
      if (booth_req[rr_sum[IdxW-1:0]]) pick = rr_sum[IdxW-1:0];
    end
  end

  // Ballot check: exactly one bit set and the targeted counter not yet saturated.
  always_comb begin
    cand = '0;
    for (int c = 0; c < NUM_CAND; c++) begin
      if (ballot_q[c]) cand = CIdxW'(c);
    end
    ballot_ok = ($countones(ballot_q) == 1) && (cnt_q[cand] != '1);
  end

  // Session FSM, grant latch, counters and registered ack/nack pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      last_q   <= IdxW'(NUM_BOOTHS - 1);
      gnt_q    <= '0;
      ballot_q <= '0;
      total_q  <= '0;
      rej_q    <= '0;
      ack_q    <= '0;
      nack_q   <= '0;
      for (int c = 0; c < NUM_CAND; c++) cnt_q[c] <= '0;
    end else begin
      ack_q  <= '0;
      nack_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (session_open) state_q <= StOpen;
        end
        StOpen: begin
          if (session_close) begin
            state_q <= StClosed;
          end else if (|booth_req) begin
            gnt_q    <= pick;
            ballot_q <= booth_vote[pick*NUM_CAND +: NUM_CAND];
            state_q  <= StCommit;
          end
        end
        StCommit: begin
          if (ballot_ok) begin
            cnt_q[cand]  <= cnt_q[cand] + CNT_W'(1);
            total_q      <= total_q + (CNT_W+2)'(1);
            ack_q[gnt_q] <= 1'b1;
          end else begin
            if (rej_q != '1) rej_q <= rej_q + CNT_W'(1);
            nack_q[gnt_q] <= 1'b1;
          end
          last_q  <= gnt_q;
          // A close seen during the commit still lets this ballot finish.
          state_q <= session_close ? StClosed : StOpen;
        end
        StClosed: begin
          state_q <= StClosed;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Pack counters onto the flat tally bus.
  always_comb begin
    tally = '0;
    for (int c = 0; c < NUM_CAND; c++) tally[c*CNT_W +: CNT_W] = cnt_q[c];
  end

  assign booth_ack     = ack_q;
  assign booth_nack    = nack_q;
  assign total_votes   = total_q;
  assign reject_count  = rej_q;
  assign session_state = state_q;
  assign results_valid = (state_q == StClosed);

endmodule

// File: tb/tb_booth_tally_arbiter.sv
// Bench for booth_tally_arbiter: directed scenarios followed by random sessions,
// each cycle compared against a transaction-level reference model.
module tb_booth_tally_arbiter;

  localparam int NB = 4;
  localparam int NC = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              session_open;
  logic              session_close;
  logic [NB-1:0]     booth_req;
  logic [NB*NC-1:0]  booth_vote;
  logic [NB-1:0]     booth_ack;
  logic [NB-1:0]     booth_nack;
  logic [NC*CW-1:0]  tally;
  logic [CW+1:0]     total_votes;
  logic [CW-1:0]     reject_count;
  logic [1:0]        session_state;
  logic              results_valid;

  booth_tally_arbiter #(
    .NUM_BOOTHS(NB),
    .NUM_CAND  (NC),
    .CNT_W     (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .session_open (session_open),
    .session_close(session_close),
    .booth_req    (booth_req),
    .booth_vote   (booth_vote),
    .booth_ack    (booth_ack),
    .booth_nack   (booth_nack),
    .tally        (tally),
    .total_votes  (total_votes),
    .reject_count (reject_count),
    .session_state(session_state),
    .results_valid(results_valid)
  );

  always #5 clk = ~clk;

  // Reference model state
  int            m_phase;  // 0 idle, 1 accepting, 2 ballot in flight, 3 closed
  int            m_last;
  int            m_g;
  logic [NC-1:0] m_ballot;
  int            m_tally [NC];
  int            m_rej;
  logic [NB-1:0] m_ack;
  logic [NB-1:0] m_nack;

  int n_vec = 0;
  int n_err = 0;
  bit keep_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Apply the rules of one clock edge to the model using the inputs present at it.
  function automatic void model_edge();
    int c;
    int idx;
    m_ack  = '0;
    m_nack = '0;
    if (rst) begin
      m_phase = 0;
      m_last  = NB - 1;
      m_rej   = 0;
      for (int i = 0; i < NC; i++) m_tally[i] = 0;
    end else begin
      case (m_phase)
        0: if (session_open) m_phase = 1;
        1: begin
          if (session_close) m_phase = 3;
          else if (booth_req != '0) begin
            for (int k = 1; k <= NB; k++) begin
              idx = (m_last + k) % NB;
              if (booth_req[idx]) begin
                m_g = idx;
                break;
              end
            end
            m_ballot = booth_vote[m_g*NC +: NC];
            m_phase  = 2;
          end
        end
        2: begin
          c = -1;
          if ($countones(m_ballot) == 1) begin
            for (int i = 0; i < NC; i++) if (m_ballot[i]) c = i;
          end
          if (c >= 0 && m_tally[c] < CMAX) begin
            m_tally[c]++;
            m_ack[m_g] = 1'b1;
          end else begin
            if (m_rej < CMAX) m_rej++;
            m_nack[m_g] = 1'b1;
          end
          m_last  = m_g;
          m_phase = session_close ? 3 : 1;
        end
        default: ;
      endcase
    end
  endfunction

  // One clock: model the edge, compare all outputs, clear pulses, retire answered booths.
  task automatic cyc();
    logic [NC*CW-1:0] exp_tally;
    int sum;
    @(posedge clk);
    model_edge();
    #1;
    exp_tally = '0;
    sum = 0;
    for (int i = 0; i < NC; i++) begin
      exp_tally[i*CW +: CW] = CW'(m_tally[i]);
      sum += m_tally[i];
    end
    check("ack", 64'(booth_ack), 64'(m_ack));
    check("nack", 64'(booth_nack), 64'(m_nack));
    check("state", 64'(session_state), 64'(m_phase));
    check("results_valid", 64'(results_valid), 64'(m_phase == 3));
    check("tally", 64'(tally), 64'(exp_tally));
    check("total_votes", 64'(total_votes), 64'(sum));
    check("reject_count", 64'(reject_count), 64'(m_rej));
    session_open  = 1'b0;
    session_close = 1'b0;
    rst           = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if ((m_ack[i] || m_nack[i]) && !(keep_en && $urandom_range(7) == 0)) booth_req[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    booth_req = '0;
    cyc();
  endtask

  function automatic logic [NC-1:0] rand_ballot();
    if ($urandom_range(9) < 7) return NC'(1) << $urandom_range(NC - 1);
    return NC'($urandom);
  endfunction

  int n;

  initial begin
    rst = 1'b1;
    session_open = 1'b0;
    session_close = 1'b0;
    booth_req = '0;
    booth_vote = '0;
    cyc();
    cyc();
    check("reset_tally", 64'(tally), 64'd0);
    check("reset_state", 64'(session_state), 64'd0);

    // 1: requests ignored while idle
    booth_vote[2*NC +: NC] = 4'b0001;
    booth_req[2] = 1'b1;
    repeat (4) cyc();
    check("t1_state", 64'(session_state), 64'd0);
    check("t1_total", 64'(total_votes), 64'd0);
    booth_req = '0;

    // 2: single valid ballot for candidate C
    session_open = 1'b1;
    cyc();
    booth_vote[1*NC +: NC] = 4'b0100;
    booth_req[1] = 1'b1;
    cyc();
    cyc();
    check("t2_ack", 64'(booth_ack), 64'b0010);
    check("t2_tallyC", 64'(tally[2*CW +: CW]), 64'd1);
    check("t2_total", 64'(total_votes), 64'd1);
    cyc();

    // 3: four simultaneous requesters served 0,1,2,3 every other cycle
    do_reset();
    for (int i = 0; i < NB; i++) booth_vote[i*NC +: NC] = NC'(1) << i;
    booth_req = '1;
    session_open = 1'b1;
    cyc();
    for (int k = 1; k <= 8; k++) begin
      cyc();
      check("t3_ack_order", 64'(booth_ack), (k % 2 == 0) ? (64'd1 << (k / 2 - 1)) : 64'd0);
    end
    check("t3_tally", 64'(tally), 64'h1111);

    // 4: empty and multi-hot ballots rejected
    booth_vote[3*NC +: NC] = 4'b0000;
    booth_req[3] = 1'b1;
    cyc();
    cyc();
    check("t4_nack0", 64'(booth_nack), 64'b1000);
    booth_vote[3*NC +: NC] = 4'b0011;
    booth_req[3] = 1'b1;
    cyc();
    cyc();
    check("t4_nack1", 64'(booth_nack), 64'b1000);
    check("t4_reject", 64'(reject_count), 64'd2);
    check("t4_tally", 64'(tally), 64'h1111);

    // 5: saturation of candidate A
    do_reset();
    session_open = 1'b1;
    cyc();
    booth_vote[0 +: NC] = 4'b0001;
    n = 0;
    for (int k = 0; k < 16; k++) begin
      booth_req[0] = 1'b1;
      cyc();
      cyc();
      if (booth_ack[0]) n++;
    end
    check("t5_acks", 64'(n), 64'd15);
    check("t5_tallyA", 64'(tally[0 +: CW]), 64'd15);
    check("t5_reject", 64'(reject_count), 64'd1);

    // 6: close during commit still counts the ballot, then everything is frozen
    booth_vote[2*NC +: NC] = 4'b0010;
    booth_req[2] = 1'b1;
    cyc();
    session_close = 1'b1;
    cyc();
    check("t6_ack", 64'(booth_ack), 64'b0100);
    check("t6_state", 64'(session_state), 64'd3);
    check("t6_valid", 64'(results_valid), 64'd1);
    check("t6_tallyB", 64'(tally[1*CW +: CW]), 64'd1);
    for (int k = 0; k < 5; k++) begin
      booth_req = '1;
      session_open = 1'b1;
      cyc();
    end
    check("t6_frozen", 64'(total_votes), 64'd16);
    do_reset();
    check("t6_rst_tally", 64'(tally), 64'd0);
    check("t6_rst_reject", 64'(reject_count), 64'd0);
    check("t6_rst_state", 64'(session_state), 64'd0);

    // Random sessions with occasional mid-session reset and open/close collisions
    keep_en = 1'b1;
    for (int s = 0; s < 6; s++) begin
      do_reset();
      for (int t = 0; t < 300; t++) begin
        for (int i = 0; i < NB; i++) begin
          if (!booth_req[i] && $urandom_range(2) == 0) begin
            booth_vote[i*NC +: NC] = rand_ballot();
            booth_req[i] = 1'b1;
          end
        end
        if ($urandom_range(19) == 0) session_open = 1'b1;
        if ($urandom_range(149) == 0) session_close = 1'b1;
        if ($urandom_range(499) == 0) rst = 1'b1;
        cyc();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
